serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 13 +
 rtl/serial_adder_full_adder_cell.sv | 25 ++
 rtl/serial_adder.sv | 105 ++++++++++
 tb/tb_serial_adder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// default operand width.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// One-bit full adder assembled from two half-adder stages; the stage carries
// are ORed since they can never both be set.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  logic s1;
  logic c1;
  logic c2;

  // first half adder: a + b
  assign s1 = a ^ b;
  assign c1 = a & b;

  // second half adder: partial sum + carry-in
  assign s  = s1 ^ cin;
  assign c2 = s1 & cin;

  assign co = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock, with a
// start/busy/done handshake. Define SERIAL_ADDER_SUB_EN to add a 'sub'
// input that turns the operation into a - b (cout=1 means no borrow).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_co;

  // operand capture values; subtraction uses a + ~b + 1
  logic [WIDTH-1:0] b_load;
  logic             c_load;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  full_adder_cell u_fa (
    .a   (ra[0]),
    .b   (rb[0]),
    .cin (carry),
    .s   (fa_s),
    .co  (fa_co)
  );

  // control FSM and datapath registers; all outputs are registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ra    <= '0;
      rb    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            ra    <= a;
            rb    <= b_load;
            carry <= c_load;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          carry <= fa_co;
          sum   <= {fa_s, sum[WIDTH-1:1]};
          ra    <= ra >> 1;
          rb    <= rb >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            cout  <= fa_co;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed cases with literal
// expectations plus randomized traffic checked every cycle against a
// timeline/arithmetic model.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int nchecks = 0;
  int nerr    = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  // standalone full adder cell
  logic fa_a, fa_b, fa_c, fa_s, fa_co;
  full_adder_cell u_fa_chk (.a(fa_a), .b(fa_b), .cin(fa_c), .s(fa_s), .co(fa_co));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // An accepted operation at edge acc is busy for edges acc..acc+W-1 after
  // it, done right after edge acc+W, result = a + b + cin (or a - b).
  int           ecount = 0;
  int           acc = 0;
  bit           active = 0;
  logic [W:0]   pend = '0;
  logic [W:0]   held = '0;
  bit           hv = 1;

  always @(posedge clk) begin
    ecount++;
    if (!rst_n) begin
      active = 0;
      held   = '0;
      hv     = 1;
    end else if (start && (!active || (ecount - 1 - acc) >= W)) begin
      acc    = ecount;
      active = 1;
      hv     = 0;
`ifdef SERIAL_ADDER_SUB_EN
      if (sub) pend = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      else     pend = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
`else
      pend = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
`endif
    end
  end

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    int d;
    bit eb, ed;
    if (!rst_n) begin
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_sum",  {24'd0, sum},  32'd0);
      chk("rst_cout", {31'd0, cout}, 32'd0);
    end else begin
      d  = ecount - acc;
      eb = active && (d < W);
      ed = active && (d == W);
      chk("busy", {31'd0, busy}, {31'd0, eb});
      chk("done", {31'd0, done}, {31'd0, ed});
      if (ed) begin
        chk("sum_done",  {24'd0, sum},  {24'd0, pend[W-1:0]});
        chk("cout_done", {31'd0, cout}, {31'd0, pend[W]});
        held = pend;
        hv   = 1;
      end else if (!eb && hv) begin
        chk("sum_hold",  {24'd0, sum},  {24'd0, held[W-1:0]});
        chk("cout_hold", {31'd0, cout}, {31'd0, held[W]});
      end
    end
  end

  // ---------------- driver helpers ----------------
  // Raise start at a negedge; returns at the next negedge with start low,
  // one half-cycle after the accepting edge.
  task automatic op_start(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tc, input logic ts);
    a = ta; b = tb_v; cin = tc;
`ifdef SERIAL_ADDER_SUB_EN
    sub = ts;
`else
    if (ts) $display("note: sub requested without SERIAL_ADDER_SUB_EN");
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_result(input string nm, input logic [W-1:0] es, input logic ec);
    chk({nm, "_sum"},  {24'd0, sum},  {24'd0, es});
    chk({nm, "_cout"}, {31'd0, cout}, {31'd0, ec});
  endtask

  initial begin
    int n;
    int t;

    // full adder cell, all 8 combinations
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic [1:0] r;
      v = 3'(i);
      fa_a = v[0]; fa_b = v[1]; fa_c = v[2];
      #1;
      r = 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
      chk("fa_s",  {31'd0, fa_s},  {31'd0, r[0]});
      chk("fa_co", {31'd0, fa_co}, {31'd0, r[1]});
    end

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_sum",  {24'd0, sum},  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic add with latency check
    op_start(8'h0F, 8'h01, 1'b0, 1'b0);
    wait_done(n);
    chk("basic_latency", 32'(n), 32'd8);
    check_result("basic", 8'h10, 1'b0);
    @(negedge clk);

    // overflow cases
    op_start(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done(n);
    check_result("ovf1", 8'h00, 1'b1);
    @(negedge clk);
    op_start(8'hFF, 8'hFF, 1'b1, 1'b0);
    wait_done(n);
    check_result("ovf2", 8'hFF, 1'b1);
    @(negedge clk);

    // start during SHIFT is ignored
    op_start(8'h33, 8'h11, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a = 8'h55; b = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    t = 3 + n;
    chk("busyprot_latency", 32'(t), 32'd8);
    check_result("busyprot", 8'h44, 1'b0);

    // back-to-back: start in the DONE cycle
    op_start(8'h20, 8'h22, 1'b0, 1'b0);
    wait_done(n);
    chk("b2b_spacing", 32'(n + 1), 32'd9);
    check_result("b2b", 8'h42, 1'b0);
    @(negedge clk);

    // reset in the middle of an operation
    op_start(8'hAA, 8'h55, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_sum",  {24'd0, sum},  32'd0);
    chk("midrst_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk("midrst_nodone", {31'd0, done}, 32'd0);
    end
    op_start(8'h12, 8'h34, 1'b1, 1'b0);
    wait_done(n);
    chk("postrst_latency", 32'(n), 32'd8);
    check_result("postrst", 8'h47, 1'b0);
    @(negedge clk);

`ifdef SERIAL_ADDER_SUB_EN
    op_start(8'h10, 8'h01, 1'b0, 1'b1);
    wait_done(n);
    check_result("sub1", 8'h0F, 1'b1);
    @(negedge clk);
    op_start(8'h01, 8'h02, 1'b1, 1'b1);
    wait_done(n);
    check_result("sub2", 8'hFF, 1'b0);
    @(negedge clk);
`endif

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 500; i++) begin
      start = ($urandom_range(0, 3) == 0);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      sub = 1'($urandom);
`endif
      @(negedge clk);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
